// File: rtl/vram_write_buffer.sv
// CPU-side VRAM write FIFO that drains into the VRAM write port only during blanking,
// plus a sticky frame-start interrupt.
module vram_write_buffer #(
   parameter int AW           = 11,
   parameter int DEPTH        = 8,
   parameter bit DRAIN_ACTIVE = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cpu_we,
   input  logic [AW-1:0]              cpu_addr,
   input  logic [7:0]                 cpu_wdata,
   output logic                       cpu_rdy,
   input  logic                       de,
   input  logic                       frame,
   output logic                       vram_we,
   output logic [AW-1:0]              vram_waddr,
   output logic [7:0]                 vram_wdata,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   output logic                       irq_frame,
   input  logic                       irq_ack
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [AW+7:0]  mem [DEPTH];
   logic [AW+7:0]  head;
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  level;
   logic           push, pop, drop;

   // cpu_rdy depends only on the level register, never on cpu_we.
   assign cpu_rdy    = (level != FULL);
   assign fifo_level = level;
   assign push       = cpu_we & cpu_rdy;
   assign drop       = cpu_we & ~cpu_rdy;
   assign pop        = (level != '0) & (DRAIN_ACTIVE | ~de);
   assign head       = mem[rd_ptr];

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {cpu_addr, cpu_wdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         vram_we    <= 1'b0;
         vram_waddr <= '0;
         vram_wdata <= '0;
         overflow   <= 1'b0;
         irq_frame  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;

         vram_we <= pop;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            vram_waddr <= head[AW+7:8];
            vram_wdata <= head[7:0];
         end

         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;

         // Set wins over acknowledge for both sticky flags.
         if (drop)
            overflow <= 1'b1;
         else if (irq_ack)
            overflow <= 1'b0;

         if (frame)
            irq_frame <= 1'b1;
         else if (irq_ack)
            irq_frame <= 1'b0;
      end
   end

endmodule
